// File: rtl/pot_scan_ctrl_if.sv
// Purpose: bundles register-decode strobes, pot pins and status reads of the pot scan sequencer.
// Latency: none, wiring only.
// Backpressure: none, strobe-driven with no stall path.
interface pot_scan_ctrl_if #(
    parameter int NUM_POTS = 8
);
    logic                potgo_wr;
    logic                fast_scan;
    logic [NUM_POTS-1:0] pot_in;
    logic [2:0]          pot_sel;
    logic [7:0]          pot_val;
    logic [NUM_POTS-1:0] allpot;
    logic                dump_en;
    logic                scan_busy;
    logic                scan_done;

    // Register decode and pot pins drive the sequencer
    modport master (
        output potgo_wr, fast_scan, pot_in, pot_sel,
        input  pot_val, allpot, dump_en, scan_busy, scan_done
    );

    // The sequencer itself
    modport slave (
        input  potgo_wr, fast_scan, pot_in, pot_sel,
        output pot_val, allpot, dump_en, scan_busy, scan_done
    );
endinterface

// File: rtl/pot_scan_ctrl.sv
// Purpose: POTGO-driven paddle measurement: dump capacitors, release, count scan lines, latch per-pot counts.
// Latency: potgo_wr acts next cycle; pot_in reaches the latches through a 2-flop synchronizer.
// Backpressure: none; potgo_wr restarts a measurement at any time.
module pot_scan_ctrl #(
    parameter int NUM_POTS    = 8,
    parameter int LINE_CYCLES = 114,
    parameter int MAX_COUNT   = 228,
    parameter int DUMP_CYCLES = 2
) (
    input  logic          o2,
    input  logic          rst_L,
    pot_scan_ctrl_if.slave bus
);
    localparam int PW = (LINE_CYCLES > 1) ? $clog2(LINE_CYCLES) : 1;
    localparam int DW = $clog2(DUMP_CYCLES + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        DUMP = 2'd1,
        SCAN = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t              state_q;
    logic [NUM_POTS-1:0] sync1_q;
    logic [NUM_POTS-1:0] sync2_q;
    logic [NUM_POTS-1:0] allpot_q;
    logic [7:0]          pot_q [NUM_POTS];
    logic [7:0]          line_cnt_q;
    logic [PW-1:0]       presc_q;
    logic [DW-1:0]       dump_cnt_q;
    logic                dump_en_q;
    logic                scan_busy_q;
    logic                scan_done_q;

    logic                tick;
    logic                at_max;
    logic [NUM_POTS-1:0] hit;
    logic [NUM_POTS-1:0] remain;
    logic [7:0]          pot_val_d;

    // Two-flop synchronizer for the asynchronous comparator outputs
    always_ff @(posedge o2 or negedge rst_L) begin
        if (!rst_L) begin
            sync1_q <= '0;
            sync2_q <= '0;
        end else begin
            sync1_q <= bus.pot_in;
            sync2_q <= sync1_q;
        end
    end

    // Line tick and per-pot crossing detection for the current scan line
    always_comb begin
        tick = 1'b0;
        if (state_q == SCAN) begin
            tick = bus.fast_scan || (presc_q == PW'(LINE_CYCLES - 1));
        end
        at_max = (line_cnt_q == 8'(MAX_COUNT));
        hit    = allpot_q & sync2_q;
        remain = allpot_q & ~hit;
    end

    // Sequencer: state, line count, prescaler, dump timer and registered status outputs
    always_ff @(posedge o2 or negedge rst_L) begin
        if (!rst_L) begin
            state_q     <= IDLE;
            line_cnt_q  <= '0;
            presc_q     <= '0;
            dump_cnt_q  <= '0;
            dump_en_q   <= 1'b1;
            scan_busy_q <= 1'b0;
            scan_done_q <= 1'b0;
        end else begin
            scan_done_q <= 1'b0;
            if (bus.potgo_wr) begin
                // A new POTGO overrides everything, including a terminal tick
                state_q     <= DUMP;
                line_cnt_q  <= '0;
                presc_q     <= '0;
                dump_cnt_q  <= '0;
                dump_en_q   <= 1'b1;
                scan_busy_q <= 1'b1;
            end else begin
                case (state_q)
                    DUMP: begin
                        if (dump_cnt_q == DW'(DUMP_CYCLES - 1)) begin
                            state_q   <= SCAN;
                            dump_en_q <= 1'b0;
                        end else begin
                            dump_cnt_q <= dump_cnt_q + DW'(1);
                        end
                    end
                    SCAN: begin
                        if (bus.fast_scan || (presc_q == PW'(LINE_CYCLES - 1))) begin
                            presc_q <= '0;
                        end else begin
                            presc_q <= presc_q + PW'(1);
                        end
                        if (tick) begin
                            if (at_max || (remain == '0)) begin
                                state_q     <= DONE;
                                dump_en_q   <= 1'b1;
                                scan_busy_q <= 1'b0;
                                scan_done_q <= 1'b1;
                            end else begin
                                line_cnt_q <= line_cnt_q + 8'd1;
                            end
                        end
                    end
                    default: begin
                        // IDLE and DONE hold until the next POTGO
                    end
                endcase
            end
        end
    end

    // POT latches and ALLPOT: capture the line count when a still-counting pot crosses
    always_ff @(posedge o2 or negedge rst_L) begin
        if (!rst_L) begin
            allpot_q <= '1;
            for (int i = 0; i < NUM_POTS; i++) begin
                pot_q[i] <= '0;
            end
        end else if (bus.potgo_wr) begin
            allpot_q <= '1;
            for (int i = 0; i < NUM_POTS; i++) begin
                pot_q[i] <= '0;
            end
        end else if (tick) begin
            for (int i = 0; i < NUM_POTS; i++) begin
                if (hit[i]) begin
                    pot_q[i] <= line_cnt_q;
                end else if (at_max && allpot_q[i]) begin
                    pot_q[i] <= 8'(MAX_COUNT);
                end
            end
            allpot_q <= at_max ? '0 : remain;
        end
    end

    // POTn read mux; selects beyond the implemented pots read zero
    always_comb begin
        pot_val_d = '0;
        for (int i = 0; i < NUM_POTS; i++) begin
            if (bus.pot_sel == 3'(i)) begin
                pot_val_d = pot_q[i];
            end
        end
    end

    assign bus.pot_val   = pot_val_d;
    assign bus.allpot    = allpot_q;
    assign bus.dump_en   = dump_en_q;
    assign bus.scan_busy = scan_busy_q;
    assign bus.scan_done = scan_done_q;

endmodule

// File: tb/tb_pot_scan_ctrl.sv
`timescale 1ns/1ps
module tb_pot_scan_ctrl;
    localparam int NP    = 8;
    localparam int LC    = 114;
    localparam int MAXC  = 228;
    localparam int DC    = 2;
    localparam int NEVER = 100000;

    logic o2;
    logic rst_L;
    int   checks;
    int   errors;

    pot_scan_ctrl_if #(.NUM_POTS(NP)) bus ();

    pot_scan_ctrl #(
        .NUM_POTS(NP), .LINE_CYCLES(LC), .MAX_COUNT(MAXC), .DUMP_CYCLES(DC)
    ) dut (
        .o2    (o2),
        .rst_L (rst_L),
        .bus   (bus.slave)
    );

    initial o2 = 1'b0;
    always #10 o2 = ~o2;

    task automatic step();
        @(posedge o2);
        #1;
    endtask

    // Edge (counted from the edge after which potgo_wr was raised) at which tick k takes effect
    function automatic int te(input bit fast, input int k);
        if (fast) return 1 + DC + 1 + k;
        return 1 + DC + LC * (k + 1);
    endfunction

    // Pot raised after edge j is visible to the latch three edges later; it takes the first tick at or after that
    function automatic int first_k(input bit fast, input int j);
        for (int k = 0; k <= MAXC; k++) begin
            if (te(fast, k) >= j + 3) return k;
        end
        return MAXC;
    endfunction

    // Issues POTGO with the given rise edges and checks status every cycle against the tick schedule.
    // abort_at: 0 = run to DONE and check latches; >0 = stop after that edge; <0 = stop that many edges before DONE.
    task automatic run_scan(input bit fast, input int rise[NP], input int abort_at, input int sel);
        int kexp[NP];
        int kmax, d, stop_n;
        logic [NP-1:0] exp_all;
        logic exp_busy, exp_done, exp_dump;
        kmax = 0;
        for (int i = 0; i < NP; i++) begin
            kexp[i] = first_k(fast, rise[i]);
            if (kexp[i] > kmax) kmax = kexp[i];
        end
        d = te(fast, kmax);
        stop_n = (abort_at > 0) ? abort_at : (abort_at < 0) ? d + abort_at : d + 2;
        bus.fast_scan = fast;
        bus.potgo_wr  = 1'b1;
        bus.pot_sel   = 3'(sel);
        for (int i = 0; i < NP; i++) bus.pot_in[i] = (rise[i] <= 0);
        for (int n = 1; n <= stop_n; n++) begin
            step();
            if (n == 1) bus.potgo_wr = 1'b0;
            for (int i = 0; i < NP; i++) if (rise[i] == n) bus.pot_in[i] = 1'b1;
            exp_busy = (n < d);
            exp_done = (n == d);
            exp_dump = (n <= DC) || (n >= d);
            for (int i = 0; i < NP; i++) exp_all[i] = (n < te(fast, kexp[i]));
            checks += 4;
            if (bus.scan_busy !== exp_busy) begin
                errors++;
                $display("FAIL scan_busy edge=%0d got %b exp %b", n, bus.scan_busy, exp_busy);
            end
            if (bus.scan_done !== exp_done) begin
                errors++;
                $display("FAIL scan_done edge=%0d got %b exp %b", n, bus.scan_done, exp_done);
            end
            if (bus.dump_en !== exp_dump) begin
                errors++;
                $display("FAIL dump_en edge=%0d got %b exp %b", n, bus.dump_en, exp_dump);
            end
            if (bus.allpot !== exp_all) begin
                errors++;
                $display("FAIL allpot edge=%0d got %h exp %h", n, bus.allpot, exp_all);
            end
            if (n == 1) begin
                checks++;
                if (bus.pot_val !== 8'd0) begin
                    errors++;
                    $display("FAIL pot_cleared sel=%0d got %0d exp 0", sel, bus.pot_val);
                end
            end
        end
        if (abort_at == 0) begin
            for (int i = 0; i < NP; i++) begin
                bus.pot_sel = 3'(i);
                #1;
                checks++;
                if (bus.pot_val !== 8'(kexp[i])) begin
                    errors++;
                    $display("FAIL pot_val pot=%0d got %0d exp %0d", i, bus.pot_val, kexp[i]);
                end
            end
        end
    endtask

    task automatic read_check(input int sel, input int exp, input string name);
        bus.pot_sel = 3'(sel);
        #1;
        checks++;
        if (bus.pot_val !== 8'(exp)) begin
            errors++;
            $display("FAIL %s got %0d exp %0d", name, bus.pot_val, exp);
        end
    endtask

    task automatic test_reset();
        int r[NP];
        // Power-on values while reset is held
        checks += 3;
        if (bus.allpot !== 8'hFF) begin errors++; $display("FAIL por_allpot got %h exp ff", bus.allpot); end
        if (bus.dump_en !== 1'b1) begin errors++; $display("FAIL por_dump_en got %b exp 1", bus.dump_en); end
        if (bus.scan_busy !== 1'b0) begin errors++; $display("FAIL por_busy got %b exp 0", bus.scan_busy); end
        rst_L = 1'b1;
        // Mid-scan asynchronous reset with some pots already latched
        for (int i = 0; i < NP; i++) r[i] = (i < 4) ? 5 * i : NEVER;
        run_scan(1'b1, r, 50, 0);
        #4;
        rst_L = 1'b0;
        #1;
        checks += 4;
        if (bus.allpot !== 8'hFF) begin errors++; $display("FAIL rst_allpot got %h exp ff", bus.allpot); end
        if (bus.dump_en !== 1'b1) begin errors++; $display("FAIL rst_dump_en got %b exp 1", bus.dump_en); end
        if (bus.scan_busy !== 1'b0) begin errors++; $display("FAIL rst_busy got %b exp 0", bus.scan_busy); end
        if (bus.scan_done !== 1'b0) begin errors++; $display("FAIL rst_done got %b exp 0", bus.scan_done); end
        for (int i = 0; i < NP; i++) read_check(i, 0, "rst_pot");
        step();
        step();
        rst_L = 1'b1;
        for (int n = 0; n < 6; n++) step();
        checks += 3;
        if (bus.scan_busy !== 1'b0) begin errors++; $display("FAIL idle_busy got %b exp 0", bus.scan_busy); end
        if (bus.dump_en !== 1'b1) begin errors++; $display("FAIL idle_dump_en got %b exp 1", bus.dump_en); end
        if (bus.allpot !== 8'hFF) begin errors++; $display("FAIL idle_allpot got %h exp ff", bus.allpot); end
    endtask

    task automatic test_fast_scan();
        int r[NP];
        for (int i = 0; i < NP; i++) r[i] = NEVER;
        r[0] = 11;
        r[1] = 30;
        run_scan(1'b1, r, 0, 3);
        read_check(0, 10, "fast_pot0");
        read_check(1, 29, "fast_pot1");
    endtask

    task automatic test_normal_scan();
        int r[NP];
        for (int i = 0; i < NP; i++) r[i] = NEVER;
        r[5] = 0;
        r[3] = 228;
        run_scan(1'b0, r, 235, 5);
        read_check(5, 0, "normal_pot5");
        read_check(3, 1, "normal_pot3");
    endtask

    task automatic test_no_crossing();
        int r[NP];
        for (int i = 0; i < NP; i++) r[i] = NEVER;
        run_scan(1'b1, r, 0, 1);
        read_check(7, MAXC, "nocross_pot7");
    endtask

    task automatic test_restart();
        int r[NP];
        for (int i = 0; i < NP; i++) r[i] = NEVER;
        r[2] = 41;
        run_scan(1'b1, r, 103, 0);
        read_check(2, 40, "restart_pot2_before");
        for (int i = 0; i < NP; i++) r[i] = 0;
        run_scan(1'b1, r, 0, 2);
        read_check(2, 0, "restart_pot2_after");
    endtask

    task automatic test_early_done();
        int r[NP];
        for (int i = 0; i < NP; i++) r[i] = 8;
        run_scan(1'b1, r, 0, 4);
        read_check(4, 7, "early_pot4");
    endtask

    task automatic test_potgo_terminal();
        int r[NP];
        for (int i = 0; i < NP; i++) r[i] = NEVER;
        run_scan(1'b1, r, -1, 6);
        for (int i = 0; i < NP; i++) r[i] = (i == 6) ? 20 : NEVER;
        run_scan(1'b1, r, 0, 6);
    endtask

    task automatic test_random();
        int r[NP];
        for (int t = 0; t < 6; t++) begin
            for (int i = 0; i < NP; i++) begin
                if ($urandom_range(0, 3) == 0) r[i] = NEVER;
                else r[i] = int'($urandom_range(0, 240));
            end
            run_scan(1'b1, r, 0, t);
        end
    endtask

    initial begin
        checks        = 0;
        errors        = 0;
        rst_L         = 1'b0;
        bus.potgo_wr  = 1'b0;
        bus.fast_scan = 1'b0;
        bus.pot_in    = '0;
        bus.pot_sel   = '0;
        step();
        step();
        test_reset();
        test_fast_scan();
        test_normal_scan();
        test_no_crossing();
        test_restart();
        test_early_done();
        test_potgo_terminal();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/pot_scan_ctrl.md
Name: pot_scan_ctrl

Overview:
Sequencer for the POKEY potentiometer (paddle) datapath. A POTGO strobe starts a measurement cycle: dump the pot capacitors, release them, then count scan lines. Each pot's count is latched when its comparator input crosses threshold, and ALLPOT tracks the pots still counting. The block sits between the register decode (POTGO/SKCTL strobes, POTn/ALLPOT reads) and the analog pot pins (comparator inputs, dump transistor enable).

Parameters:
NUM_POTS, 8, number of pot channels (1..8)
LINE_CYCLES, 114, o2 cycles per scan line in normal mode (>=2)
MAX_COUNT, 228, terminal line count; pots not crossed by then latch this value
DUMP_CYCLES, 2, o2 cycles the dump transistors are held on after POTGO (>=1)

Ports:
o2  input  1  system clock; all state changes on its rising edge
rst_L  input  1  asynchronous active-low reset
potgo_wr  input  1  one-cycle strobe, CPU write to POTGO
fast_scan  input  1  SKCTL bit 2; 1 = one line tick per o2 cycle
pot_in  input  NUM_POTS  raw comparator outputs, 1 = capacitor above threshold
pot_sel  input  3  POTn read select
pot_val  output  8  value of the selected POT latch (combinational mux)
allpot  output  NUM_POTS  1 = pot still counting (not yet latched)
dump_en  output  1  1 = dump transistors on, capacitors discharged
scan_busy  output  1  1 while in DUMP or SCAN
scan_done  output  1  one-cycle pulse on entry to DONE

Behaviour:
- Clock is o2. Reset rst_L is asynchronous and active-low, with no synchronous reset path.
- Reset values: state IDLE, all POT latches 0, allpot all 1s, dump_en 1, scan_busy 0, scan_done 0, line count 0, prescaler 0, synchronizer flops 0.
- pot_in passes through a 2-flop synchronizer (pin to usable value: 2 cycles). All comparisons below use the synchronized value.
- States:
  - IDLE: dump_en 1. potgo_wr -> DUMP.
  - DUMP: dump_en 1, scan_busy 1. Lasts exactly DUMP_CYCLES cycles, then -> SCAN.
  - SCAN: dump_en 0, scan_busy 1.
  - DONE: dump_en 1, scan_busy 0, latches held. potgo_wr -> DUMP.
- potgo_wr in any state, including mid-SCAN and mid-DUMP, takes effect the next cycle. It enters DUMP, clears all POT latches to 0, sets allpot to all 1s, and clears the line count, prescaler and dump counter.
- Tick generation in SCAN:
  - fast_scan 0: prescaler counts 0..LINE_CYCLES-1; a tick occurs in the cycle where prescaler == LINE_CYCLES-1, then the prescaler wraps to 0.
  - fast_scan 1: a tick occurs every SCAN cycle and the prescaler is held at 0.
  - A fast_scan change mid-scan applies from the next cycle; the line count is not disturbed.
- On a tick with line count C:
  - For each i with allpot[i]=1 and synced pot_in[i]=1: POT[i] <= C, allpot[i] <= 0.
  - If C == MAX_COUNT: every still-set allpot[i] latches POT[i] <= MAX_COUNT and clears, then -> DONE.
  - Else if all allpot bits become 0 on this tick: -> DONE early.
  - Else C <= C+1.
  - Tick k (0-based) therefore sees C = k.
- The line count is 8 bits and never exceeds MAX_COUNT, so there is no wrap.
- Pots whose allpot bit is already 0 ignore pot_in; a latched value is never overwritten until the next potgo_wr.
- scan_done is high for exactly the first cycle in DONE.
- pot_val = POT[pot_sel]. pot_sel >= NUM_POTS reads 0.
- allpot bits at positions >= NUM_POTS read as 0.
- Simultaneous potgo_wr and a terminal tick: potgo_wr wins. Go to DUMP, no scan_done pulse.

Test Plan:
1. Reset: assert rst_L=0 mid-SCAN asynchronously -> same cycle allpot=8'hFF, all POT=0, dump_en=1, scan_busy=0; after release, stays in IDLE.
2. Fast scan: fast_scan=1, potgo_wr, pot_in[0] held low then raised so the synced value is first 1 at tick 10 -> POT0=10, allpot=8'hFE; other pots continue counting.
3. Normal scan: fast_scan=0, pot_in[5]=1 from before potgo_wr -> first tick 2+114 cycles after DUMP entry, POT5=0, allpot[5]=0, next tick 114 cycles later.
4. No crossing: fast_scan=1, pot_in=0 -> on tick 228 all POT=228, allpot=0, one-cycle scan_done, dump_en=1, scan_busy=0.
5. Restart: potgo_wr while C=100 with POT2=40 latched -> next cycle DUMP, POT2=0, allpot=8'hFF, dump_en=1, count restarts at 0.
6. Early done: all 8 pot_in high at tick 7 -> all POT=7, DONE entered on that tick, scan_done pulse.
